// File: rtl/bcd_cntr_chain_ctrl_pkg.sv
// Shared definitions for the BCD counter chain controller.
// Contents: controller state encoding, BCD digit width and the decade
// terminal value shared by the top level and the digit stages.
package bcd_cntr_chain_ctrl_pkg;

    localparam int                 DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/bcd_cntr_chain_ctrl_digit_stage.sv
// One synchronous decade (0..9) stage of the BCD counter chain.
// Ports:
//   clk     - system clock, rising edge
//   rstn    - synchronous active-low reset
//   clr     - synchronous clear to 0
//   en      - advance by one this edge (wraps 9 -> 0)
//   q       - current BCD digit
//   at_nine - digit currently holds 9; feeds the next stage's enable
module bcd_digit_stage
    import bcd_cntr_chain_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               clr,
    input  logic               en,
    output logic [DIGIT_W-1:0] q,
    output logic               at_nine
);

    // NOTE: state registers use non-blocking assignments so every stage
    // samples its neighbours' pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            q <= '0;
        end else if (en) begin
            q <= at_nine ? '0 : q + 4'd1;
        end
    end

    assign at_nine = (q == BCD_MAX);

endmodule

// File: rtl/bcd_cntr_chain_ctrl.sv
// Sequencer for a cascade of BCD decade stages (stopwatch / event timer).
// Owns the tick prescaler, the IDLE/RUN/PAUSE/DONE FSM, the synchronous
// carry-enable chain, terminal-value detection and the lap register.
// Ports:
//   clk, rstn   - clock and synchronous active-low reset
//   start/stop  - resume / pause counting (clear > stop > start)
//   clear       - zero digits, prescaler and lap; return to IDLE
//   lap         - capture the live count into lap_digits (RUN/PAUSE only)
//   limit_en    - enable stop at the terminal value in limit
//   limit       - BCD terminal value, digit i at [4i+3:4i]
//   digits      - live BCD count
//   lap_digits  - last captured count; lap_valid pulses the cycle after capture
//   running/done- registered state decodes
//   overflow    - one-cycle pulse when all-9s wraps to 0
module bcd_cntr_chain_ctrl
    import bcd_cntr_chain_ctrl_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                lap,
    input  logic                limit_en,
    input  logic [4*DIGITS-1:0] limit,
    output logic [4*DIGITS-1:0] digits,
    output logic [4*DIGITS-1:0] lap_digits,
    output logic                lap_valid,
    output logic                running,
    output logic                done,
    output logic                overflow
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    state_e              state, state_nxt;
    logic [PW-1:0]       psc;
    logic                tick, inc_en, lap_take, limit_hit, carry;
    logic [DIGITS-1:0]   at_nine, chain_en;
    logic [4*DIGITS-1:0] post_val;

    assign tick = (state == ST_RUN) && (psc == PW'(PRESCALE - 1));
    // A tick coinciding with stop or clear is dropped, not deferred.
    assign inc_en   = tick && !stop && !clear;
    assign lap_take = lap && !clear && (state == ST_RUN || state == ST_PAUSE);

    // Enable chain: digit i advances when every lower digit is 9. post_val is
    // the value the digits will hold after this edge, used for limit matching.
    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned (which would infer a latch).
    always_comb begin
        chain_en = '0;
        post_val = digits;
        carry    = inc_en;
        for (int i = 0; i < DIGITS; i++) begin
            chain_en[i] = carry;
            if (carry) begin
                post_val[4*i +: 4] = at_nine[i] ? 4'd0 : digits[4*i +: 4] + 4'd1;
            end
            carry = carry && at_nine[i];
        end
    end

    // Post-increment value is always BCD, so non-BCD limit nibbles never match.
    assign limit_hit = limit_en && (post_val == limit);

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:  if (start) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (stop)                        state_nxt = ST_PAUSE;
                    else if (inc_en && limit_hit)    state_nxt = ST_DONE;
                end
                ST_PAUSE: if (start) state_nxt = ST_RUN;
                ST_DONE:  state_nxt = ST_DONE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            psc        <= '0;
            lap_digits <= '0;
            lap_valid  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state     <= state_nxt;
            overflow  <= inc_en && (&at_nine);
            lap_valid <= lap_take;
            if (clear) begin
                psc        <= '0;
                lap_digits <= '0;
            end else begin
                // Prescaler holds through the stop cycle so no partial tick is lost.
                if (state == ST_RUN && !stop) begin
                    psc <= tick ? '0 : psc + PW'(1);
                end
                if (lap_take) begin
                    lap_digits <= digits;
                end
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_stage u_stage (
            .clk     (clk),
            .rstn    (rstn),
            .clr     (clear),
            .en      (chain_en[g]),
            .q       (digits[4*g +: 4]),
            .at_nine (at_nine[g])
        );
    end

    assign running = (state == ST_RUN);
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_bcd_cntr_chain_ctrl.sv
// Self-checking bench: directed scenarios plus randomized commands, compared
// every cycle against an integer-count reference model.
module tb_bcd_cntr_chain_ctrl;

    localparam int D   = 2;
    localparam int P   = 3;
    localparam int MOD = 100;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic           clk = 1'b0;
    logic           rstn, start, stop, clear, lap, limit_en;
    logic [4*D-1:0] limit;
    logic [4*D-1:0] digits, lap_digits;
    logic           lap_valid, running, done, overflow;

    int n_checks = 0;
    int n_errors = 0;

    int m_mode, m_cnt, m_psc, m_lap;
    bit m_lapv, m_ovf;
    int dut_ovf_pulses;

    always #5 clk = ~clk;

    bcd_cntr_chain_ctrl #(.DIGITS(D), .PRESCALE(P)) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .lap        (lap),
        .limit_en   (limit_en),
        .limit      (limit),
        .digits     (digits),
        .lap_digits (lap_digits),
        .lap_valid  (lap_valid),
        .running    (running),
        .done       (done),
        .overflow   (overflow)
    );

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [4*D-1:0] x);
        int acc;
        acc = 0;
        for (int i = D - 1; i >= 0; i--) acc = acc * 10 + int'(x[4*i +: 4]);
        return acc;
    endfunction

    function automatic bit is_bcd(input logic [4*D-1:0] x);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < D; i++) if (x[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    always @(negedge clk) begin
        if (rstn === 1'b1 && limit_en === 1'b1)
            assert (is_bcd(limit)) else $error("limit holds a non-BCD nibble");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the count is a plain integer modulo 10^D.
    task automatic model_step();
        bit tk;
        m_ovf  = 1'b0;
        m_lapv = 1'b0;
        if (!rstn || clear) begin
            m_mode = M_IDLE; m_cnt = 0; m_psc = 0; m_lap = 0;
            return;
        end
        tk = (m_mode == M_RUN) && (m_psc == P - 1);
        if (lap && (m_mode == M_RUN || m_mode == M_PAUSE)) begin
            m_lap  = m_cnt;
            m_lapv = 1'b1;
        end
        case (m_mode)
            M_IDLE:  if (start) m_mode = M_RUN;
            M_PAUSE: if (start) m_mode = M_RUN;
            M_RUN: begin
                if (stop) begin
                    m_mode = M_PAUSE;
                end else begin
                    m_psc = (m_psc + 1) % P;
                    if (tk) begin
                        m_cnt = (m_cnt + 1) % MOD;
                        m_ovf = (m_cnt == 0);
                        if (limit_en && m_cnt == from_bcd(limit)) m_mode = M_DONE;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic step(input logic r, input logic s, input logic sp,
                        input logic c, input logic l);
        rstn = r; start = s; stop = sp; clear = c; lap = l;
        model_step();
        @(posedge clk);
        #1;
        if (overflow === 1'b1) dut_ovf_pulses++;
        check("digits",     32'(digits),     32'(to_bcd(m_cnt)));
        check("lap_digits", 32'(lap_digits), 32'(to_bcd(m_lap)));
        check("lap_valid",  32'(lap_valid),  32'(m_lapv));
        check("running",    32'(running),    32'(m_mode == M_RUN));
        check("done",       32'(done),       32'(m_mode == M_DONE));
        check("overflow",   32'(overflow),   32'(m_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    task automatic run_until_count(input int target, input string tag);
        int budget;
        budget = 2000;
        while (m_cnt != target && budget > 0) begin
            step(1, 0, 0, 0, 0);
            budget--;
        end
        check({tag, "_reached"}, 32'(budget > 0), 32'd1);
    endtask

    initial begin
        rstn = 1'b0; start = 0; stop = 0; clear = 0; lap = 0;
        limit_en = 1'b0; limit = '0;
        m_mode = M_IDLE; m_cnt = 0; m_psc = 0; m_lap = 0; m_lapv = 0; m_ovf = 0;
        dut_ovf_pulses = 0;

        // Reset state, then reset mid-run at count 37.
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 1);
        step(1, 1, 0, 0, 0);
        run_until_count(37, "pre_reset");
        step(0, 1, 0, 0, 1);
        check("reset_digits", 32'(digits), 32'd0);

        // Cascade through 09 -> 10 and on to a single overflow wrap.
        step(1, 1, 0, 0, 0);
        dut_ovf_pulses = 0;
        idle(320);
        check("ovf_pulse_count", 32'(dut_ovf_pulses), 32'd1);
        check("running_after_wrap", 32'(running), 32'd1);
        step(1, 0, 0, 1, 0);

        // Terminal value 25: DONE, start and stop ignored, clear to IDLE.
        limit = to_bcd(25); limit_en = 1'b1;
        step(1, 1, 0, 0, 0);
        idle(90);
        check("limit_done", 32'(done), 32'd1);
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 1);
        step(1, 0, 0, 1, 0);

        // Limit of zero fires only at the overflow wrap.
        limit = '0;
        step(1, 1, 0, 0, 0);
        dut_ovf_pulses = 0;
        idle(310);
        check("limit0_done", 32'(done), 32'd1);
        check("limit0_ovf",  32'(dut_ovf_pulses), 32'd1);
        step(1, 0, 0, 1, 0);
        limit_en = 1'b0;

        // Pause/resume, then stop coincident with a tick.
        step(1, 1, 0, 0, 0);
        idle(7);
        step(1, 0, 1, 0, 0);
        idle(8);
        step(1, 1, 0, 0, 0);
        idle(6);
        begin
            int budget;
            budget = 20;
            while (!(m_mode == M_RUN && m_psc == P - 1) && budget > 0) begin
                step(1, 0, 0, 0, 0);
                budget--;
            end
            check("tick_align", 32'(budget > 0), 32'd1);
        end
        step(1, 0, 1, 0, 0);
        idle(3);
        step(1, 1, 0, 0, 0);
        idle(4);
        step(1, 0, 0, 1, 0);

        // Lap capture, lap with clear, clear with start.
        step(1, 1, 0, 0, 0);
        run_until_count(13, "lap_count");
        step(1, 0, 0, 0, 1);
        check("lap_13", 32'(lap_digits), 32'(to_bcd(13)));
        idle(2);
        step(1, 0, 0, 1, 1);
        step(1, 1, 0, 1, 0);
        idle(2);

        // Randomized commands against the model.
        for (int c = 0; c < 4000; c++) begin
            if (c % 150 == 0) begin
                limit    = to_bcd(int'($urandom_range(0, MOD - 1)));
                limit_en = ($urandom_range(0, 2) == 0);
            end
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_cntr_chain_ctrl.md
Name: bcd_cntr_chain_ctrl

Overview:
Sequencer for a cascade of DIGITS synchronous BCD decade stages (stopwatch/event-timer style). It owns a count-tick prescaler, a run/pause/done FSM, the synchronous carry-enable chain between digits, terminal-value (limit) detection, and a lap capture register. Software/user controls are start, stop, clear and lap; outputs feed display and status logic.

Parameters:
DIGITS, 4, number of cascaded BCD digits (1..8); digit 0 is least significant
PRESCALE, 10, clk cycles per count tick (>=1; 1 means tick every cycle in RUN)

Ports:
clk  input  1  system clock, all logic rising-edge
rstn  input  1  synchronous active-low reset
start  input  1  level/pulse; begin or resume counting
stop  input  1  pause counting
clear  input  1  zero digits, prescaler, lap; return to IDLE
lap  input  1  capture current count into lap_digits
limit_en  input  1  enable terminal-value stop
limit  input  4*DIGITS  BCD terminal value, digit i at [4i+3:4i]
digits  output  4*DIGITS  live BCD count
lap_digits  output  4*DIGITS  last captured count
lap_valid  output  1  one-cycle pulse, cycle after capture
running  output  1  high in RUN
done  output  1  high in DONE
overflow  output  1  one-cycle pulse on all-9s wrap to 0

Behaviour:
- Reset (rstn=0 at clk edge): state IDLE, digits=0, lap_digits=0, prescaler=0, running=done=overflow=lap_valid=0. Reset wins over every input.
- States: IDLE, RUN, PAUSE, DONE (2-bit encoding).
- Command priority per cycle: clear > stop > start. Lap is independent of commands.
- IDLE: start -> RUN. stop ignored.
- RUN: stop -> PAUSE; clear -> IDLE. Prescaler counts 0..PRESCALE-1, wraps; tick asserted combinationally when prescaler==PRESCALE-1 in RUN.
- PAUSE: prescaler and digits hold; start -> RUN (prescaler resumes from held value, no partial tick lost); clear -> IDLE.
- DONE: digits hold; start and stop ignored; clear -> IDLE.
- clear from any state: next cycle digits=0, prescaler=0, lap_digits=0, state IDLE. clear with start in same cycle -> IDLE (start dropped).
- Increment: on tick, digit i advances iff all digits 0..i-1 equal 9 (synchronous enable chain, no ripple clocks). Digit at 9 with enable -> 0; values only 0..9 reachable.
- Overflow: tick with all digits 9 -> all 0, overflow pulses 1 cycle (same edge as wrap), state stays RUN.
- Limit: if limit_en and the post-increment value equals limit, on that same edge digits take the limit value and state -> DONE; done=1 from next cycle. Limit compared only on ticks; changing limit mid-run below current value never triggers (counter runs to overflow). limit_en with limit=0 fires only after overflow wrap to 0, overflow also pulses that cycle.
- stop and tick in same cycle: tick's increment is not applied; state -> PAUSE, digits hold.
- Lap: lap high in RUN or PAUSE captures digits as presented before that edge's increment; lap_valid pulses next cycle. Lap ignored in IDLE/DONE; lap with clear -> clear wins, no capture.
- running and done are registered state decodes (no combinational input paths to outputs except none).
- Non-BCD limit nibbles (A-F): never match; documented as illegal, assertion in bench.

Decomposition:
- Shared package: state enum constants (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE), BCD_MAX=4'd9, digit-width constant 4.
- One sub-module: bcd_digit_stage (4-bit decade register, inputs en/clr, outputs q and at_nine); instantiated DIGITS times by generate; controller builds the enable chain from at_nine.
- Prescaler and FSM stay in the top.

Test Plan:
- Reset: rstn=0 mid-RUN with digits=0x0037 -> next cycle digits=0, state IDLE, all status 0.
- Cascade (DIGITS=2, PRESCALE=2): start, run 20 cycles -> digits 0x09 then 0x10 on 10th tick; never 0x0A.
- Overflow (DIGITS=2, PRESCALE=1): run 100 cycles -> 0x99 -> 0x00 with overflow high exactly 1 cycle, still running.
- Limit: limit_en=1, limit=0x25, PRESCALE=1 -> digits stop at 0x25, done=1, start ignored, clear -> 0x00 IDLE.
- Pause/resume: PRESCALE=4, stop on cycle prescaler=2 -> digits hold 8 cycles; start -> next tick 2 cycles later; stop coincident with tick -> no increment.
- Lap/priority: lap at digits=0x13 -> lap_digits=0x13, lap_valid pulse; lap+clear same cycle -> lap_digits=0, no lap_valid; clear+start -> IDLE.
